bcd_scan_display: RTL and testbench

- Parametrised multi-digit time-multiplexed BCD/hex to 7-segment driver; successor to the single-digit combinational BCD_segment decoder.
- Latches a packed multi-digit value and scans one digit at a time through shared segment lines.
- Adds per-digit decimal points, leading-zero blanking, selectable display polarity and a frame-done strobe.
- Sits between the system-side value register and the board display pins.

---
 rtl/bcd_scan_display.sv | 146 ++++++++++++++
 tb/tb_bcd_scan_display.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ==== bcd_scan_display : time-multiplexed BCD/hex 7-segment scan driver ====
// ==== rev 1.0                                                            ====
module bcd_scan_display #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int ACTIVE_LOW = 1,
   parameter int BLANK_LZ   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [7:0]              segment,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);

   localparam int c_presc_w = $clog2(SCAN_DIV);
   localparam int c_idx_w   = $clog2(NUM_DIGITS);
   localparam logic c_inv   = (ACTIVE_LOW != 0);
   localparam logic c_blank = (BLANK_LZ != 0);
   localparam logic [7:0]            c_seg_off   = {8{c_inv}};
   localparam logic [NUM_DIGITS-1:0] c_en_off    = {NUM_DIGITS{c_inv}};
   localparam logic [c_presc_w-1:0]  c_presc_max = c_presc_w'(SCAN_DIV - 1);
   localparam logic [c_idx_w-1:0]    c_idx_max   = c_idx_w'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d;
   logic [c_presc_w-1:0]    presc_q, presc_d;
   logic [c_idx_w-1:0]      idx_q, idx_d;
   logic [7:0]              segment_q, segment_d;
   logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic                    frame_done_q, frame_done_d;

   logic                    w_tick;
   logic [c_idx_w-1:0]      w_idx_next;
   logic [NUM_DIGITS-1:0]   w_lead_zero;
   logic [NUM_DIGITS-1:0]   w_sel;
   logic [3:0]              w_nib;
   logic                    w_dp;
   logic                    w_blank;
   logic                    w_zero_run;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   // Glyph is built from the shadow next-state so a load coincident with a tick shows at once.
   always_comb begin
      val_d      = load ? bcd_in : val_q;
      dp_d       = load ? dp_in  : dp_q;
      w_tick     = (presc_q == c_presc_max);
      w_idx_next = (idx_q == c_idx_max) ? '0 : idx_q + c_idx_w'(1);
   end

   always_comb begin
      w_zero_run  = 1'b1;
      w_lead_zero = '0;
      w_sel       = '0;
      w_nib       = 4'h0;
      w_dp        = 1'b0;
      w_blank     = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_run     = w_zero_run & (val_d[4*i +: 4] == 4'h0);
         w_lead_zero[i] = w_zero_run;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (c_idx_w'(i) == w_idx_next) begin
            w_sel[i] = 1'b1;
            w_nib    = val_d[4*i +: 4];
            w_dp     = dp_d[i];
            w_blank  = c_blank & w_lead_zero[i] & (i != 0);
         end
      end
   end

   always_comb begin
      presc_d      = presc_q;
      idx_d        = idx_q;
      segment_d    = segment_q;
      digit_en_d   = digit_en_q;
      frame_done_d = 1'b0;
      if (!enable) begin
         presc_d    = '0;
         idx_d      = '0;
         segment_d  = c_seg_off;
         digit_en_d = c_en_off;
      end else if (w_tick) begin
         presc_d      = '0;
         idx_d        = w_idx_next;
         segment_d    = {w_dp, (w_blank ? 7'h00 : glyph(w_nib))} ^ c_seg_off;
         digit_en_d   = w_sel ^ c_en_off;
         frame_done_d = (w_idx_next == '0);
      end else begin
         presc_d = presc_q + c_presc_w'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q        <= '0;
         dp_q         <= '0;
         presc_q      <= '0;
         idx_q        <= '0;
         segment_q    <= c_seg_off;
         digit_en_q   <= c_en_off;
         frame_done_q <= 1'b0;
      end else begin
         val_q        <= val_d;
         dp_q         <= dp_d;
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         segment_q    <= segment_d;
         digit_en_q   <= digit_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign segment    = segment_q;
   assign digit_en   = digit_en_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ==== tb_bcd_scan_display : checks three polarity/blanking variants against a frame-time model ====
module tb_bcd_scan_display;

   localparam int N = 4;
   localparam int S = 4;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        enable = 1'b0;
   logic        load   = 1'b0;
   logic [15:0] bcd_in = 16'h0;
   logic [3:0]  dp_in  = 4'h0;

   logic [7:0] seg_a, seg_b, seg_c;
   logic [3:0] en_a, en_b, en_c;
   logic       fd_a, fd_b, fd_c;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   always #5 clk = ~clk;

   // a: active-high, no blanking; b: active-high, blanking; c: active-low, blanking
   bcd_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(S), .ACTIVE_LOW(0), .BLANK_LZ(0)) u_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
      .segment(seg_a), .digit_en(en_a), .frame_done(fd_a));
   bcd_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(S), .ACTIVE_LOW(0), .BLANK_LZ(1)) u_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
      .segment(seg_b), .digit_en(en_b), .frame_done(fd_b));
   bcd_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(S), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_c (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
      .segment(seg_c), .digit_en(en_c), .frame_done(fd_c));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {segment, digit_en} for digit d showing value v.
   function automatic logic [11:0] model_out(input bit al, input bit blz, input logic [15:0] v,
                                             input logic [3:0] dp, input int d);
      logic [7:0] s;
      logic [3:0] e;
      logic [15:0] upper;
      upper  = v >> (4 * d);
      s[6:0] = (blz && d != 0 && upper == 16'h0) ? 7'h00 : glyph_tab[int'(upper & 16'hF)];
      s[7]   = dp[d];
      e      = 4'(1 << d);
      if (al) begin
         s = ~s;
         e = ~e;
      end
      return {s, e};
   endfunction

   // Model: t counts enabled edges; every S-th edge lights digit (t/S) mod N.
   int          m_t   = 0;
   logic [15:0] m_val = 16'h0;
   logic [3:0]  m_dp  = 4'h0;
   logic [11:0] ex_a  = 12'h000;
   logic [11:0] ex_b  = 12'h000;
   logic [11:0] ex_c  = 12'hFFF;
   logic        ex_fd = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t   <= 0;
         m_val <= 16'h0;
         m_dp  <= 4'h0;
         ex_a  <= 12'h000;
         ex_b  <= 12'h000;
         ex_c  <= 12'hFFF;
         ex_fd <= 1'b0;
      end else begin
         m_val <= load ? bcd_in : m_val;
         m_dp  <= load ? dp_in  : m_dp;
         if (!enable) begin
            m_t   <= 0;
            ex_a  <= 12'h000;
            ex_b  <= 12'h000;
            ex_c  <= 12'hFFF;
            ex_fd <= 1'b0;
         end else begin
            m_t <= m_t + 1;
            if ((m_t + 1) % S == 0) begin
               ex_a  <= model_out(1'b0, 1'b0, load ? bcd_in : m_val, load ? dp_in : m_dp, ((m_t + 1) / S) % N);
               ex_b  <= model_out(1'b0, 1'b1, load ? bcd_in : m_val, load ? dp_in : m_dp, ((m_t + 1) / S) % N);
               ex_c  <= model_out(1'b1, 1'b1, load ? bcd_in : m_val, load ? dp_in : m_dp, ((m_t + 1) / S) % N);
               ex_fd <= (((m_t + 1) / S) % N) == 0;
            end else begin
               ex_fd <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("seg_a", 32'(seg_a), 32'(ex_a[11:4]));
      check("en_a",  32'(en_a),  32'(ex_a[3:0]));
      check("seg_b", 32'(seg_b), 32'(ex_b[11:4]));
      check("en_b",  32'(en_b),  32'(ex_b[3:0]));
      check("seg_c", 32'(seg_c), 32'(ex_c[11:4]));
      check("en_c",  32'(en_c),  32'(ex_c[3:0]));
      check("fd_a",  32'(fd_a),  32'(ex_fd));
      check("fd_b",  32'(fd_b),  32'(ex_fd));
      check("fd_c",  32'(fd_c),  32'(ex_fd));
   end

   // Returns at the first falling edge of a fresh slot for digit d (timed from instance a).
   task automatic wait_slot(input int d);
      int n;
      n = 0;
      while (en_a == 4'(1 << d) && n < 64) begin
         @(negedge clk);
         n++;
      end
      while (en_a != 4'(1 << d) && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_slot_%0d: got timeout, expected digit %0d within 64 cycles", d, d);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      logic [3:0] seq_en  [4];
      logic [7:0] seq_seg [4];
      seq_en  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      seq_seg = '{8'h5B, 8'h4F, 8'h66, 8'h06};

      repeat (2) @(negedge clk);
      check("rst_seg_a", 32'(seg_a), 32'h00);
      check("rst_en_a",  32'(en_a),  32'h0);
      check("rst_seg_c", 32'(seg_c), 32'hFF);
      check("rst_en_c",  32'(en_c),  32'hF);
      check("rst_fd_a",  32'(fd_a),  32'h0);
      rst_n = 1'b1;

      // digit0=1, digit1=2, digit2=3, digit3=4
      bcd_in = 16'h4321;
      load   = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("dark_seg_a", 32'(seg_a), 32'h00);
      repeat (2) @(negedge clk);
      check("dark_en_a", 32'(en_a), 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("seq_en",  32'(en_a),  32'(seq_en[k]));
         check("seq_seg", 32'(seg_a), 32'(seq_seg[k]));
         check("seq_fd",  32'(fd_a),  (k == 3) ? 32'h1 : 32'h0);
         if (k < 3) repeat (3) @(negedge clk);
      end
      @(negedge clk);
      check("fd_one_cycle", 32'(fd_a), 32'h0);

      for (int v = 0; v < 16; v++) begin
         wait_slot(1);
         bcd_in = 16'h4320 | 16'(v);
         load   = 1'b1;
         @(negedge clk);
         load = 1'b0;
         wait_slot(0);
         check("sweep", 32'(seg_a), 32'({1'b0, glyph_tab[v]}));
         if (v == 10) check("sweep_A", 32'(seg_a), 32'h77);
         if (v == 15) check("sweep_F", 32'(seg_a), 32'h71);
         if (v == 8)  check("sweep_8", 32'(seg_a), 32'h7F);
      end

      bcd_in = 16'h0700;
      dp_in  = 4'b0100;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_slot(3);
      check("lz_d3_b",  32'(seg_b), 32'h00);
      check("lz_d3_en", 32'(en_b),  32'b1000);
      check("lz_d3_c",  32'(seg_c), 32'hFF);
      check("lz_d3_a",  32'(seg_a), 32'h3F);
      wait_slot(2);
      check("lz_d2_b", 32'(seg_b), 32'h87);
      check("lz_d2_c", 32'(seg_c), 32'h78);
      wait_slot(1);
      check("lz_d1_b", 32'(seg_b), 32'h3F);
      wait_slot(0);
      check("lz_d0_c", 32'(seg_c), 32'hC0);

      bcd_in = 16'h0000;
      dp_in  = 4'b0000;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_slot(2);
      check("zero_d2_b",  32'(seg_b), 32'h00);
      check("zero_d2_en", 32'(en_b),  32'b0100);
      wait_slot(0);
      check("zero_d0_b", 32'(seg_b), 32'h3F);

      bcd_in = 16'h0008;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_slot(0);
      check("al_seg_c", 32'(seg_c), 32'h80);
      check("al_en_c",  32'(en_c),  32'b1110);

      // Mid-digit load must not disturb the lit digit; load on the tick edge shows at once.
      wait_slot(3);
      bcd_in = 16'h5009;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("mid_load_hold", 32'(seg_a), 32'h3F);
      repeat (2) @(negedge clk);
      bcd_in = 16'h0006;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("tick_load_seg", 32'(seg_a), 32'h7D);
      check("tick_load_en",  32'(en_a),  32'b0001);

      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("dis_seg_a", 32'(seg_a), 32'h00);
      check("dis_en_c",  32'(en_c),  32'hF);
      repeat (2) @(negedge clk);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("reen_dark", 32'(en_a), 32'h0);
      @(negedge clk);
      check("reen_en_a",  32'(en_a),  32'b0010);
      check("reen_seg_a", 32'(seg_a), 32'h3F);
      check("reen_seg_b", 32'(seg_b), 32'h00);
      wait_slot(0);
      check("reen_keep", 32'(seg_a), 32'h7D);

      #2;
      rst_n = 1'b0;
      #1;
      check("arst_seg_a", 32'(seg_a), 32'h00);
      check("arst_en_a",  32'(en_a),  32'h0);
      check("arst_seg_c", 32'(seg_c), 32'hFF);
      check("arst_en_c",  32'(en_c),  32'hF);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_en_a",  32'(en_a),  32'b0010);
      check("post_rst_seg_a", 32'(seg_a), 32'h3F);
      check("post_rst_seg_c", 32'(seg_c), 32'hFF);
      check("post_rst_en_c",  32'(en_c),  32'b1101);
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
